// File: rtl/frame_sequencer.sv
// frame_sequencer
//   Sequences the window_buffer frame datapath: waits for the initial fill,
//   drains FRAME_SIZE samples per frame through a registered valid/ready
//   output, then requests the next hop (start_move) once window_buffer is idle.
//   Each output sample carries its index plus first/last markers.
//
// Optional feature: define FRAME_SEQ_ZERO_PAD_EN to append zero samples
//   (indices FRAME_SIZE..FFT_SIZE-1) to every frame; out_last_o then marks
//   index FFT_SIZE-1 instead of FRAME_SIZE-1.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   enable_i                run; low lets the current frame finish, then halts
//   wb_start_move_o         one-cycle hop request to window_buffer
//   wb_rd_en_o              combinational read strobe to window_buffer
//   wb_read_data_i          sample from window_buffer
//   wb_valid_to_read_i      sample available
//   wb_start_next_state_i   window_buffer hop/fill start acknowledge
//   wb_idle_i               window_buffer is idle
//   out_valid_o/out_ready_i output handshake
//   out_data_o              sample
//   out_index_o             position within the frame
//   out_first_o/out_last_o  frame boundary markers
//   frame_count_o           completed (accepted) frames, wraps
//   busy_o                  low only while halted
module frame_sequencer #(
  parameter int WIDTH      = 16,
  parameter int FRAME_SIZE = 306,
  parameter int FFT_SIZE   = 512,
  parameter int IDX_W      = $clog2(FFT_SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  output logic             wb_start_move_o,
  output logic             wb_rd_en_o,
  input  logic [WIDTH-1:0] wb_read_data_i,
  input  logic             wb_valid_to_read_i,
  input  logic             wb_start_next_state_i,
  input  logic             wb_idle_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [IDX_W-1:0] out_index_o,
  output logic             out_first_o,
  output logic             out_last_o,
  output logic [15:0]      frame_count_o,
  output logic             busy_o
);

  generate
    if (FFT_SIZE < FRAME_SIZE) begin : g_size_chk
      $error("frame_sequencer: FFT_SIZE must be >= FRAME_SIZE");
    end
  endgenerate

`ifdef FRAME_SEQ_ZERO_PAD_EN
  localparam int LAST_IDX = FFT_SIZE - 1;
`else
  localparam int LAST_IDX = FRAME_SIZE - 1;
`endif
  localparam logic [IDX_W-1:0] FRAME_END = IDX_W'(FRAME_SIZE - 1);
  localparam logic [IDX_W-1:0] LAST_END  = IDX_W'(LAST_IDX);

  typedef enum logic [2:0] {
    ST_WAIT_FILL = 3'd0,
    ST_STREAM    = 3'd1,
    ST_WAIT_IDLE = 3'd2,
    ST_MOVE      = 3'd3,
    ST_WAIT_ACK  = 3'd4,
    ST_HALT      = 3'd5
`ifdef FRAME_SEQ_ZERO_PAD_EN
    , ST_PAD     = 3'd6
`endif
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_sample_cnt, w_cnt_nxt;
  logic               r_out_valid, r_out_first, r_out_last;
  logic [WIDTH-1:0]   r_out_data, w_load_data;
  logic [IDX_W-1:0]   r_out_index;
  logic [15:0]        r_frame_count;
  logic               w_can_load, w_load, w_rd_en, w_move;

  // Output register can take a new sample when empty or draining this cycle.
  assign w_can_load = !r_out_valid || out_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_sample_cnt;
    w_rd_en     = 1'b0;
    w_move      = 1'b0;
    w_load      = 1'b0;
    w_load_data = '0;
    case (r_state)
      ST_WAIT_FILL: if (wb_valid_to_read_i) w_state_nxt = ST_STREAM;
      ST_STREAM: begin
        w_rd_en = wb_valid_to_read_i && w_can_load;
        if (w_rd_en) begin
          w_load      = 1'b1;
          w_load_data = wb_read_data_i;
          w_cnt_nxt   = r_sample_cnt + 1'b1;
          if (r_sample_cnt == FRAME_END) begin
`ifdef FRAME_SEQ_ZERO_PAD_EN
            w_state_nxt = (FFT_SIZE > FRAME_SIZE) ? ST_PAD : ST_WAIT_IDLE;
`else
            w_state_nxt = ST_WAIT_IDLE;
`endif
          end
        end
      end
`ifdef FRAME_SEQ_ZERO_PAD_EN
      // Zero fill without touching window_buffer; counter continues from FRAME_SIZE.
      ST_PAD: begin
        if (w_can_load) begin
          w_load    = 1'b1;
          w_cnt_nxt = r_sample_cnt + 1'b1;
          if (r_sample_cnt == LAST_END) w_state_nxt = ST_WAIT_IDLE;
        end
      end
`endif
      ST_WAIT_IDLE: begin
        if (!enable_i)      w_state_nxt = ST_HALT;
        else if (wb_idle_i) w_state_nxt = ST_MOVE;
      end
      ST_MOVE: begin
        w_move      = 1'b1;
        w_state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (wb_start_next_state_i) begin
          w_state_nxt = ST_STREAM;
          w_cnt_nxt   = '0;
        end
      end
      ST_HALT: if (enable_i && wb_idle_i) w_state_nxt = ST_MOVE;
      default: w_state_nxt = ST_WAIT_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_WAIT_FILL;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_cnt  <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_index   <= '0;
      r_out_first   <= 1'b0;
      r_out_last    <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_sample_cnt <= w_cnt_nxt;
      // Load and drain may coincide, keeping one sample per cycle.
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_load_data;
        r_out_index <= r_sample_cnt;
        r_out_first <= (r_sample_cnt == '0);
        r_out_last  <= (r_sample_cnt == LAST_END);
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end
      if (r_out_valid && out_ready_i && r_out_last)
        r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign wb_rd_en_o      = w_rd_en;
  assign wb_start_move_o = w_move;
  assign out_valid_o     = r_out_valid;
  assign out_data_o      = r_out_data;
  assign out_index_o     = r_out_index;
  assign out_first_o     = r_out_first;
  assign out_last_o      = r_out_last;
  assign frame_count_o   = r_frame_count;
  assign busy_o          = (r_state != ST_HALT);

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Controller that sequences the `window_buffer` frame datapath and streams its frames downstream. Issues `start_move` hops, drains exactly FRAME_SIZE samples per frame through a registered valid/ready output port, and tags each sample with index and first/last markers. Optionally zero-pads each frame to FFT_SIZE. Sits between `window_buffer` and the windowing/FFT stage of the MFCC pipeline.

## Interface
- WIDTH, 16, sample width
- FRAME_SIZE, 306, samples per frame; must match the `window_buffer` instance
- FFT_SIZE, 512, padded frame length; power of two, ≥ FRAME_SIZE
- IDX_W, $clog2(FFT_SIZE), width of the index output

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable_i  in  1  run; when low, the current frame finishes and no new hop is issued
- wb_start_move_o  out  1  one-cycle hop request to `window_buffer`
- wb_rd_en_o  out  1  read strobe to `window_buffer`, combinational
- wb_read_data_i  in  WIDTH  sample from `window_buffer`
- wb_valid_to_read_i  in  1  sample available
- wb_start_next_state_i  in  1  `window_buffer` hop/fill start acknowledge
- wb_idle_i  in  1  `window_buffer` is in IDLE
- out_valid_o  out  1  output sample valid
- out_ready_i  in  1  downstream accepts
- out_data_o  out  WIDTH  sample
- out_index_o  out  IDX_W  position within the frame
- out_first_o  out  1  index 0
- out_last_o  out  1  final sample of the frame
- frame_count_o  out  16  completed frames, wraps
- busy_o  out  1  state ≠ HALT

## Operation
- States:
  - WAIT_FILL (reset state)
  - STREAM
  - PAD (macro only)
  - WAIT_IDLE
  - MOVE
  - WAIT_ACK
  - HALT
- WAIT_FILL → STREAM on `wb_valid_to_read_i`. This covers the initial fill after reset.
- STREAM:
  - `wb_rd_en_o = wb_valid_to_read_i && (!out_valid_o || out_ready_i)`.
  - Each assertion is one transfer. `wb_read_data_i` is captured the same cycle.
  - `sample_cnt` runs 0..FRAME_SIZE-1.
  - After transfer FRAME_SIZE-1: go to PAD if the macro is set, else WAIT_IDLE.
- PAD: emits zeros with indices FRAME_SIZE..FFT_SIZE-1 and makes no `window_buffer` reads. After the last zero is loaded, go to WAIT_IDLE.
- WAIT_IDLE:
  - If `!enable_i`, go to HALT.
  - Else if `wb_idle_i`, go to MOVE.
- MOVE: `wb_start_move_o = 1` for exactly one cycle, then WAIT_ACK.
- WAIT_ACK: on `wb_start_next_state_i`, go to STREAM and clear `sample_cnt`.
- HALT: on `enable_i` high and `wb_idle_i`, go to MOVE.
- `frame_count_o` increments by 1 when the `out_last_o` sample is accepted downstream (`out_valid_o && out_ready_i`). Wraps 0xFFFF → 0.
- `out_first_o` = (`out_index_o` == 0). `out_last_o` = (`out_index_o` == last index):
  - last index = FRAME_SIZE-1 without the macro;
  - last index = FFT_SIZE-1 with the macro.
- Elaboration error if FFT_SIZE < FRAME_SIZE.

## Timing
- Reset values:
  - all outputs 0;
  - `busy_o` 1 (state is WAIT_FILL);
  - `sample_cnt` 0.
- The `window_buffer` also resets to its fill state, so the two stay aligned.
- Output register:
  - Latency is 1 cycle from a `wb_rd_en_o` transfer to `out_valid_o`.
  - `out_*` holds stable while `out_valid_o && !out_ready_i`.
  - Load and drain in the same cycle are allowed, giving full throughput of 1 sample/cycle.
- Backpressure: `out_ready_i` low with `out_valid_o` high forces `wb_rd_en_o` low, so no sample is lost or duplicated.
- `wb_valid_to_read_i` low mid-frame: the stream stalls, `sample_cnt` holds, and there is no timeout.
- `enable_i` drop mid-frame: the frame completes, including PAD; the block then goes to HALT.
- The last output sample may still be pending in the output register when MOVE fires. This is allowed because `window_buffer` is not read until after WAIT_ACK.
- Reset assertion mid-frame: immediate return to WAIT_FILL. The partially emitted frame is dropped and `frame_count_o` clears.

## Configuration
- FRAME_SEQ_ZERO_PAD_EN defined:
  - PAD state present;
  - every frame is FFT_SIZE output samples;
  - indices FRAME_SIZE..FFT_SIZE-1 carry zero data;
  - `out_last_o` at FFT_SIZE-1.
- Undefined:
  - PAD removed;
  - frames are FRAME_SIZE samples;
  - `out_last_o` at FRAME_SIZE-1.

## Test plan
- Reset, `enable_i`=1, model fills 306 samples with values 0..305, `out_ready_i`=1:
  - outputs 0..305 with indices 0..305;
  - `out_first_o` at index 0;
  - no-pad build: `out_last_o` at index 305, `frame_count_o`=1.
- Pad build, same stimulus:
  - 206 zeros follow at indices 306..511;
  - `out_last_o` only at index 511;
  - 512 accepted samples per frame.
- `out_ready_i` toggled 1/0 every cycle:
  - the sequence is identical to the previous test;
  - `wb_rd_en_o` never high while the output is stalled;
  - no data duplicates.
- End of frame 1 with `wb_idle_i` asserted 3 cycles later:
  - exactly one `wb_start_move_o` pulse, 1 cycle after `wb_idle_i`;
  - STREAM resumes only after `wb_start_next_state_i`.
- `enable_i` dropped at sample 100:
  - frame completes;
  - `frame_count_o` increments;
  - `busy_o`=0;
  - no `wb_start_move_o`;
  - re-enable produces one move pulse.
- `rst_n` pulsed at sample 150:
  - all outputs 0 the same cycle;
  - `frame_count_o`=0;
  - the next frame restarts at index 0.
